// File: rtl/num_check.sv
// num_check: AXI-Stream sink and scoreboard.
// Takes expected words on a side port into a small FIFO. Compares each accepted stream beat
// against the FIFO head, or against EXP_DATA directly when the FIFO is empty. Counts matches,
// mismatches and packets, and raises sticky underflow, overflow and destination errors.
// Ports:
//   CLK, RST (async, active-high), CLR (sync clear), HOLD (backpressure request)
//   EXP_VALID/EXP_DATA/EXP_READY     : expected-word push port
//   AXIS_S_*                         : AXI-Stream slave (TID ignored)
//   MATCH_CNT, MISMATCH_CNT, PKT_CNT : saturating counters
//   PKT_LEN, LAST_RX_DATA            : last packet length, last accepted data
//   ERR_UNDERFLOW/OVERFLOW/DEST      : sticky error flags
//   DONE                             : one-cycle pulse after each TLAST beat
module num_check #(
  parameter int unsigned TDATAW     = 32,
  parameter int unsigned TDESTW     = 4,
  parameter int unsigned TIDW       = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned MY_DEST    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              HOLD,
  input  logic              EXP_VALID,
  input  logic [TDATAW-1:0] EXP_DATA,
  output logic              EXP_READY,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic [CNTW-1:0]   MATCH_CNT,
  output logic [CNTW-1:0]   MISMATCH_CNT,
  output logic [CNTW-1:0]   PKT_CNT,
  output logic [CNTW-1:0]   PKT_LEN,
  output logic [TDATAW-1:0] LAST_RX_DATA,
  output logic              ERR_UNDERFLOW,
  output logic              ERR_OVERFLOW,
  output logic              ERR_DEST,
  output logic              DONE
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic unused_tid;
  assign unused_tid = ^AXIS_S_TID;

  logic [TDATAW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              tready_q;
  logic [0:0]        state_q, state_d;
  logic [CNTW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNTW-1:0]   match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
  logic [CNTW-1:0]   pkt_cnt_q, pkt_cnt_d, pkt_len_q, pkt_len_d;
  logic [TDATAW-1:0] last_rx_q, last_rx_d;
  logic              err_under_q, err_under_d, err_over_q, err_over_d;
  logic              err_dest_q, err_dest_d, done_q, done_d;

  logic              full, empty, accept, pop, bypass, wr_en, drop, do_cmp;
  logic [TDATAW-1:0] cmp_data;
  logic [CNTW-1:0]   beat_next;

  always_comb begin
    full   = (count_q == CW'(FIFO_DEPTH));
    empty  = (count_q == '0);
    accept = AXIS_S_TVALID & tready_q;
    pop    = accept & ~empty;
    // Bypass only when empty, so the FIFO can never be full here.
    bypass = accept & empty & EXP_VALID;
    // A push while full is still taken when the head pops in the same cycle.
    wr_en  = EXP_VALID & ~bypass & (~full | pop);
    drop   = EXP_VALID & full & ~pop;
    do_cmp = pop | bypass;
    cmp_data  = pop ? mem_q[rd_ptr_q] : EXP_DATA;
    beat_next = (state_q == ST_IDLE) ? CNTW'(1) : sat_inc(beat_cnt_q);
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    pkt_cnt_d      = pkt_cnt_q;
    pkt_len_d      = pkt_len_q;
    last_rx_d      = last_rx_q;
    err_under_d    = err_under_q;
    err_over_d     = err_over_q;
    err_dest_d     = err_dest_q;
    done_d         = 1'b0;
    if (CLR) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      state_d        = ST_IDLE;
      beat_cnt_d     = '0;
      match_cnt_d    = '0;
      mismatch_cnt_d = '0;
      pkt_cnt_d      = '0;
      pkt_len_d      = '0;
      last_rx_d      = '0;
      err_under_d    = 1'b0;
      err_over_d     = 1'b0;
      err_dest_d     = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
      if (drop) err_over_d = 1'b1;
      if (do_cmp) begin
        if (cmp_data == AXIS_S_TDATA) match_cnt_d    = sat_inc(match_cnt_q);
        else                          mismatch_cnt_d = sat_inc(mismatch_cnt_q);
      end
      if (accept) begin
        if (!do_cmp) err_under_d = 1'b1;
        if (AXIS_S_TDEST != TDESTW'(MY_DEST)) err_dest_d = 1'b1;
        last_rx_d  = AXIS_S_TDATA;
        beat_cnt_d = beat_next;
        if (AXIS_S_TLAST) begin
          state_d   = ST_IDLE;
          pkt_cnt_d = sat_inc(pkt_cnt_q);
          pkt_len_d = beat_next;
          done_d    = 1'b1;
        end else begin
          state_d = ST_RECV;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tready_q       <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      beat_cnt_q     <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      pkt_cnt_q      <= '0;
      pkt_len_q      <= '0;
      last_rx_q      <= '0;
      err_under_q    <= 1'b0;
      err_over_q     <= 1'b0;
      err_dest_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      tready_q       <= ~HOLD;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      pkt_cnt_q      <= pkt_cnt_d;
      pkt_len_q      <= pkt_len_d;
      last_rx_q      <= last_rx_d;
      err_under_q    <= err_under_d;
      err_over_q     <= err_over_d;
      err_dest_q     <= err_dest_d;
      done_q         <= done_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (wr_en && !CLR) mem_q[wr_ptr_q] <= EXP_DATA;
  end

  assign EXP_READY     = ~full;
  assign AXIS_S_TREADY = tready_q;
  assign MATCH_CNT     = match_cnt_q;
  assign MISMATCH_CNT  = mismatch_cnt_q;
  assign PKT_CNT       = pkt_cnt_q;
  assign PKT_LEN       = pkt_len_q;
  assign LAST_RX_DATA  = last_rx_q;
  assign ERR_UNDERFLOW = err_under_q;
  assign ERR_OVERFLOW  = err_over_q;
  assign ERR_DEST      = err_dest_q;
  assign DONE          = done_q;

endmodule

// File: tb/tb_num_check.sv
module tb_num_check;

  logic        CLK = 1'b0;
  logic        RST, CLR, HOLD, EXP_VALID, EXP_READY;
  logic [31:0] EXP_DATA;
  logic        AXIS_S_TVALID, AXIS_S_TREADY, AXIS_S_TLAST;
  logic [31:0] AXIS_S_TDATA;
  logic [1:0]  AXIS_S_TID;
  logic [3:0]  AXIS_S_TDEST;
  logic [15:0] MATCH_CNT, MISMATCH_CNT, PKT_CNT, PKT_LEN;
  logic [31:0] LAST_RX_DATA;
  logic        ERR_UNDERFLOW, ERR_OVERFLOW, ERR_DEST, DONE;

  num_check dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .HOLD(HOLD),
    .EXP_VALID(EXP_VALID), .EXP_DATA(EXP_DATA), .EXP_READY(EXP_READY),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
    .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST),
    .AXIS_S_TID(AXIS_S_TID), .AXIS_S_TDEST(AXIS_S_TDEST),
    .MATCH_CNT(MATCH_CNT), .MISMATCH_CNT(MISMATCH_CNT), .PKT_CNT(PKT_CNT),
    .PKT_LEN(PKT_LEN), .LAST_RX_DATA(LAST_RX_DATA),
    .ERR_UNDERFLOW(ERR_UNDERFLOW), .ERR_OVERFLOW(ERR_OVERFLOW),
    .ERR_DEST(ERR_DEST), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model; mq is the scoreboard of expected words awaiting a beat.
  logic [31:0] mq [$];
  logic [15:0] m_match, m_mis, m_pkt, m_len, m_beat;
  logic [31:0] m_last;
  logic        m_under, m_over, m_dest, m_done, m_tready, m_recv, m_acc;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic [3:0]  dest;
    logic [15:0] x_match;
    logic [15:0] x_pkt;
    logic        x_done;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_match = 0; m_mis = 0; m_pkt = 0; m_len = 0; m_beat = 0; m_last = 0;
    m_under = 0; m_over = 0; m_dest = 0; m_done = 0; m_recv = 0; m_acc = 0;
    m_tready = 0;
  endtask

  task automatic model_cmp(input logic [31:0] e, input logic [31:0] d);
    if (e == d) m_match++;
    else        m_mis++;
  endtask

  task automatic model_step(input logic tv, input logic [31:0] td, input logic tl,
                            input logic [3:0] tdest, input logic ev, input logic [31:0] ed,
                            input logic hold, input logic clr);
    logic full, popped, byp;
    popped = 0; byp = 0;
    m_acc  = 0;
    m_done = 0;
    if (clr) begin
      mq.delete();
      m_match = 0; m_mis = 0; m_pkt = 0; m_len = 0; m_beat = 0; m_last = 0;
      m_under = 0; m_over = 0; m_dest = 0; m_recv = 0;
    end else begin
      m_acc = tv & m_tready;
      full  = (mq.size() == 16);
      if (m_acc && mq.size() > 0) begin
        model_cmp(mq.pop_front(), td);
        popped = 1;
      end else if (m_acc && ev) begin
        model_cmp(ed, td);
        byp = 1;
      end else if (m_acc) begin
        m_under = 1;
      end
      if (ev && !byp) begin
        if (!full || popped) mq.push_back(ed);
        else                 m_over = 1;
      end
      if (m_acc) begin
        if (tdest != 4'd1) m_dest = 1;
        m_last = td;
        m_beat = m_recv ? m_beat + 16'd1 : 16'd1;
        if (tl) begin
          m_pkt++;
          m_len  = m_beat;
          m_recv = 0;
          m_done = 1;
        end else begin
          m_recv = 1;
        end
      end
    end
    m_tready = ~hold;
  endtask

  task automatic check_all();
    chk("match_cnt", MATCH_CNT, m_match);
    chk("mismatch_cnt", MISMATCH_CNT, m_mis);
    chk("pkt_cnt", PKT_CNT, m_pkt);
    chk("pkt_len", PKT_LEN, m_len);
    chk("last_rx_data", LAST_RX_DATA, m_last);
    chk("err_underflow", ERR_UNDERFLOW, m_under);
    chk("err_overflow", ERR_OVERFLOW, m_over);
    chk("err_dest", ERR_DEST, m_dest);
    chk("done", DONE, m_done);
    chk("tready", AXIS_S_TREADY, m_tready);
    chk("exp_ready", EXP_READY, mq.size() < 16);
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(input logic tv, input logic [31:0] td, input logic tl,
                     input logic [3:0] tdest, input logic ev, input logic [31:0] ed,
                     input logic hold, input logic clr);
    AXIS_S_TVALID = tv; AXIS_S_TDATA = td; AXIS_S_TLAST = tl; AXIS_S_TDEST = tdest;
    AXIS_S_TID = 2'(td);
    EXP_VALID = ev; EXP_DATA = ed; HOLD = hold; CLR = clr;
    @(posedge CLK);
    model_step(tv, td, tl, tdest, ev, ed, hold, clr);
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 4'd1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    cyc(1'b0, 32'h0, 1'b0, 4'd1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [31:0] w);
    cyc(1'b0, 32'h0, 1'b0, 4'd1, 1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    cyc(1'b1, d, last, 4'd1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " match"}, MATCH_CNT, 16'd0);
    chk({tag, " mismatch"}, MISMATCH_CNT, 16'd0);
    chk({tag, " pkt_cnt"}, PKT_CNT, 16'd0);
    chk({tag, " pkt_len"}, PKT_LEN, 16'd0);
    chk({tag, " last_rx"}, LAST_RX_DATA, 32'd0);
    chk({tag, " flags"}, {ERR_UNDERFLOW, ERR_OVERFLOW, ERR_DEST, DONE}, 4'b0000);
    chk({tag, " exp_ready"}, EXP_READY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dones, lows, idx;
    vecs[0] = '{32'h11, 1'b0, 4'd1, 16'd1, 16'd0, 1'b0};
    vecs[1] = '{32'h22, 1'b0, 4'd1, 16'd2, 16'd0, 1'b0};
    vecs[2] = '{32'h33, 1'b0, 4'd1, 16'd3, 16'd0, 1'b0};
    vecs[3] = '{32'h44, 1'b1, 4'd1, 16'd4, 16'd1, 1'b1};

    RST = 1; CLR = 0; HOLD = 0; EXP_VALID = 0; EXP_DATA = 0;
    AXIS_S_TVALID = 0; AXIS_S_TDATA = 0; AXIS_S_TLAST = 0; AXIS_S_TID = 0; AXIS_S_TDEST = 1;
    model_reset();
    #1;
    check_reset_outputs("reset");
    chk("reset tready", AXIS_S_TREADY, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    idle();

    // Basic match via bypass path, table driven.
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, vecs[i].d, vecs[i].last, vecs[i].dest, 1'b1, vecs[i].d, 1'b0, 1'b0);
      chk("vec match", MATCH_CNT, vecs[i].x_match);
      chk("vec pkt", PKT_CNT, vecs[i].x_pkt);
      chk("vec done", DONE, vecs[i].x_done);
      dones += int'(DONE);
    end
    idle();
    dones += int'(DONE);
    chk("basic done pulses", 64'(dones), 64'd1);
    chk("basic pkt_len", PKT_LEN, 16'd4);
    chk("basic mismatch", MISMATCH_CNT, 16'd0);
    chk("basic last_rx", LAST_RX_DATA, 32'h44);

    // Buffered mismatch.
    clear();
    push(32'hA5);
    push(32'h5A);
    beat(32'hA5, 1'b0);
    beat(32'h00, 1'b1);
    chk("buf match", MATCH_CNT, 16'd1);
    chk("buf mismatch", MISMATCH_CNT, 16'd1);
    chk("buf no underflow", ERR_UNDERFLOW, 1'b0);
    beat(32'h01, 1'b1);
    chk("buf fifo empty", ERR_UNDERFLOW, 1'b1);

    // Full FIFO and overflow.
    clear();
    for (int i = 0; i < 17; i++) begin
      push(32'h1000 + 32'(i));
      if (i == 15) chk("full exp_ready", EXP_READY, 1'b0);
    end
    chk("overflow flag", ERR_OVERFLOW, 1'b1);
    for (int i = 0; i < 16; i++) beat(32'h1000 + 32'(i), i == 15);
    chk("full match", MATCH_CNT, 16'd16);
    chk("full mismatch", MISMATCH_CNT, 16'd0);
    chk("full pkt_len", PKT_LEN, 16'd16);

    // Underflow and bad destination.
    clear();
    beat(32'h77, 1'b0);
    chk("underflow flag", ERR_UNDERFLOW, 1'b1);
    chk("underflow counts", {MATCH_CNT, MISMATCH_CNT}, 32'd0);
    cyc(1'b1, 32'h88, 1'b1, 4'd2, 1'b1, 32'h88, 1'b0, 1'b0);
    chk("dest flag", ERR_DEST, 1'b1);
    chk("dest match", MATCH_CNT, 16'd1);

    // Clear wins over a same-cycle beat and push.
    cyc(1'b1, 32'h99, 1'b1, 4'd2, 1'b1, 32'h99, 1'b0, 1'b1);
    check_reset_outputs("clear");
    idle();
    chk("clear no done", DONE, 1'b0);
    chk("clear no match", MATCH_CNT, 16'd0);

    // Backpressure mid-packet.
    for (int i = 0; i < 6; i++) push(32'h200 + 32'(i));
    idx = 0; lows = 0;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      cyc(1'b1, 32'h200 + 32'(idx), idx == 5, 4'd1, 1'b0, 32'h0, c >= 1 && c <= 3, 1'b0);
      if (m_acc) idx++;
      if (!AXIS_S_TREADY) lows++;
    end
    chk("bp all beats", 64'(idx), 64'd6);
    chk("bp tready low cycles", 64'(lows), 64'd3);
    chk("bp pkt_len", PKT_LEN, 16'd6);
    chk("bp match", MATCH_CNT, 16'd6);

    // Async reset mid-packet.
    cyc(1'b1, 32'h300, 1'b0, 4'd1, 1'b1, 32'h300, 1'b0, 1'b0);
    cyc(1'b1, 32'h301, 1'b0, 4'd1, 1'b1, 32'h301, 1'b0, 1'b0);
    RST = 1;
    #1;
    model_reset();
    check_reset_outputs("async reset");
    chk("async reset tready", AXIS_S_TREADY, 1'b0);
    @(negedge CLK);
    RST = 0;
    idle();
    cyc(1'b1, 32'h400, 1'b1, 4'd1, 1'b1, 32'h400, 1'b0, 1'b0);
    chk("post reset pkt_len", PKT_LEN, 16'd1);
    chk("post reset pkt_cnt", PKT_CNT, 16'd1);
    chk("post reset done", DONE, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
